lbp_hist: RTL

Downstream consumer of the LBP stage: it takes the `lbp_valid`/`lbp_addr`/`lbp_data`/`finish` stream and builds a 256-bin histogram of LBP codes. When the LBP stage raises `finish`, the block streams the histogram out over a valid/ready port and reports a pixel-count and ordering status. It sits between the LBP engine and the host-side feature readout.

---
 rtl/lbp_hist.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lbp_hist.sv
// 256-bin histogram of LBP codes. Once the frame finishes, the bins are streamed out over a
// valid/ready port, and pixel-count and address-ordering status are reported.
module lbp_hist #(
  parameter int unsigned CNT_W   = 14,
  parameter int unsigned EXP_PIX = 15876
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  input  logic             clear,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_last,
  output logic             hist_done,
  output logic             pix_err,
  output logic             order_err
);

  typedef enum logic [1:0] {StAccum, StDump, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bin_q [256];
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [13:0]        last_addr_q, last_addr_d;
  logic               first_q, first_d;
  logic               hist_valid_q, hist_valid_d;
  logic [7:0]         hist_bin_q, hist_bin_d;
  logic [CNT_W-1:0]   hist_count_q, hist_count_d;
  logic               hist_last_q, hist_last_d;
  logic               hist_done_q, hist_done_d;
  logic               pix_err_q, pix_err_d;
  logic               order_err_q, order_err_d;
  logic               bin_inc, bin_clr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    last_addr_d  = last_addr_q;
    first_d      = first_q;
    hist_valid_d = hist_valid_q;
    hist_bin_d   = hist_bin_q;
    hist_count_d = hist_count_q;
    hist_last_d  = hist_last_q;
    hist_done_d  = hist_done_q;
    pix_err_d    = pix_err_q;
    order_err_d  = order_err_q;
    bin_inc      = 1'b0;
    bin_clr      = 1'b0;
    case (state_q)
      StAccum: begin
        if (lbp_valid) begin
          bin_inc   = 1'b1;
          pix_cnt_d = sat_inc(pix_cnt_q);
          if (!first_q && (lbp_addr <= last_addr_q)) order_err_d = 1'b1;
          last_addr_d = lbp_addr;
          first_d     = 1'b0;
        end
        if (finish) begin
          state_d      = StDump;
          pix_err_d    = (pix_cnt_d != CNT_W'(EXP_PIX));
          hist_valid_d = 1'b1;
          hist_bin_d   = 8'd0;
          hist_last_d  = 1'b0;
          // Bin 0 may be incremented on this very edge; present the post-increment count.
          hist_count_d = (bin_inc && (lbp_data == 8'd0)) ? sat_inc(bin_q[0]) : bin_q[0];
        end
      end
      StDump: begin
        if (hist_ready) begin
          if (hist_bin_q == 8'hFF) begin
            state_d      = StDone;
            hist_valid_d = 1'b0;
            hist_last_d  = 1'b0;
            hist_done_d  = 1'b1;
            hist_bin_d   = 8'd0;
            hist_count_d = '0;
          end else begin
            hist_bin_d   = hist_bin_q + 8'd1;
            hist_count_d = bin_q[hist_bin_d];
            hist_last_d  = (hist_bin_d == 8'hFF);
          end
        end
      end
      StDone: begin
        if (clear) begin
          state_d     = StAccum;
          bin_clr     = 1'b1;
          pix_cnt_d   = '0;
          order_err_d = 1'b0;
          pix_err_d   = 1'b0;
          first_d     = 1'b1;
          hist_done_d = 1'b0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StAccum;
      pix_cnt_q    <= '0;
      last_addr_q  <= '0;
      first_q      <= 1'b1;
      hist_valid_q <= 1'b0;
      hist_bin_q   <= 8'd0;
      hist_count_q <= '0;
      hist_last_q  <= 1'b0;
      hist_done_q  <= 1'b0;
      pix_err_q    <= 1'b0;
      order_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      last_addr_q  <= last_addr_d;
      first_q      <= first_d;
      hist_valid_q <= hist_valid_d;
      hist_bin_q   <= hist_bin_d;
      hist_count_q <= hist_count_d;
      hist_last_q  <= hist_last_d;
      hist_done_q  <= hist_done_d;
      pix_err_q    <= pix_err_d;
      order_err_q  <= order_err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) bin_q[i] <= '0;
    end else if (bin_clr) begin
      for (int i = 0; i < 256; i++) bin_q[i] <= '0;
    end else if (bin_inc) begin
      bin_q[lbp_data] <= sat_inc(bin_q[lbp_data]);
    end
  end

  assign hist_valid = hist_valid_q;
  assign hist_bin   = hist_bin_q;
  assign hist_count = hist_count_q;
  assign hist_last  = hist_last_q;
  assign hist_done  = hist_done_q;
  assign pix_err    = pix_err_q;
  assign order_err  = order_err_q;

endmodule
